rv32im_wb_arbiter: RTL and testbench

- Owns the single write port of the integer register file.
- Merges two writeback sources:
  - in-order pipeline writeback: single-cycle ALU, load and MUL results;
  - long-latency results, i.e. the iterative DIV/REM unit, via valid/ready.
- Long-latency results are buffered in a small FIFO and drained into idle writeback slots. A starvation guard forces a drain when needed.
- Exports register-busy flags so decode can interlock on results that are not yet written.

---
 rtl/rv32im_wb_arbiter.sv | 170 +++++++++++++++++
 tb/tb_rv32im_wb_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32im_wb_arbiter.sv
// rv32im_wb_arbiter: owns the single register-file write port.
// It merges in-order pipeline writebacks with long-latency DIV/REM results.
// Long-op results are held in a small FIFO and drained into idle writeback slots.
// A starvation guard raises o_stall when the FIFO head has waited too long.
// Busy flags let decode interlock on destinations that are not yet written.

module rv32im_wb_arbiter #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 2,
    parameter int MAX_WAIT   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_pipe_valid,
    input  logic [ADDR_WIDTH-1:0] i_pipe_rd,
    input  logic [WIDTH-1:0]      i_pipe_data,
    input  logic                  i_lo_valid,
    output logic                  o_lo_ready,
    input  logic [ADDR_WIDTH-1:0] i_lo_rd,
    input  logic [WIDTH-1:0]      i_lo_data,
    output logic                  o_we,
    output logic [ADDR_WIDTH-1:0] o_rd_addr,
    output logic [WIDTH-1:0]      o_rd_data,
    input  logic [ADDR_WIDTH-1:0] i_rs1_addr,
    input  logic [ADDR_WIDTH-1:0] i_rs2_addr,
    output logic                  o_rs1_busy,
    output logic                  o_rs2_busy,
    output logic                  o_stall,
    output logic                  o_err
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    logic [ADDR_WIDTH-1:0] fifo_rd   [DEPTH];
    logic [WIDTH-1:0]      fifo_data [DEPTH];
    logic [DEPTH-1:0]      fifo_vld;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic [WAIT_W-1:0]     wait_cnt;

    logic                  empty;
    logic                  full;
    logic                  push;
    logic                  pop;
    logic                  drop;
    logic                  issue_valid;
    logic [ADDR_WIDTH-1:0] issue_rd;
    logic [WIDTH-1:0]      issue_data;
    logic                  rs1_hit;
    logic                  rs2_hit;

    assign empty      = (count == '0);
    assign full       = (count == CNT_W'(DEPTH));
    assign o_lo_ready = !full;
    assign push       = i_lo_valid && !full;
    assign o_stall    = (wait_cnt == WAIT_W'(MAX_WAIT));

    // Pick this cycle's writeback: forced drain, then pipeline, then idle-slot drain.
    always_comb begin
        issue_valid = 1'b0;
        issue_rd    = '0;
        issue_data  = '0;
        pop         = 1'b0;
        drop        = 1'b0;
        if (o_stall) begin
            drop = i_pipe_valid;
            if (!empty) begin
                issue_valid = 1'b1;
                issue_rd    = fifo_rd[rd_ptr];
                issue_data  = fifo_data[rd_ptr];
                pop         = 1'b1;
            end
        end else if (i_pipe_valid) begin
            issue_valid = 1'b1;
            issue_rd    = i_pipe_rd;
            issue_data  = i_pipe_data;
        end else if (!empty) begin
            issue_valid = 1'b1;
            issue_rd    = fifo_rd[rd_ptr];
            issue_data  = fifo_data[rd_ptr];
            pop         = 1'b1;
        end
    end

    // FIFO payload storage; contents are meaningful only where fifo_vld is set.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_rd[wr_ptr]   <= i_lo_rd;
            fifo_data[wr_ptr] <= i_lo_data;
        end
    end

    // FIFO pointers, occupancy and per-slot valid bits; reset empties the FIFO at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            fifo_vld <= '0;
        end else begin
            if (push) begin
                wr_ptr           <= wr_ptr + PTR_W'(1);
                fifo_vld[wr_ptr] <= 1'b1;
            end
            if (pop) begin
                rd_ptr           <= rd_ptr + PTR_W'(1);
                fifo_vld[rd_ptr] <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Starvation counter: counts cycles the head sits unpopped, saturating at MAX_WAIT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (empty || pop) begin
            wait_cnt <= '0;
        end else if (wait_cnt != WAIT_W'(MAX_WAIT)) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

    // Registered write port; writes to x0 are suppressed and leave addr/data unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_we      <= 1'b0;
            o_rd_addr <= '0;
            o_rd_data <= '0;
        end else if (issue_valid && (issue_rd != '0)) begin
            o_we      <= 1'b1;
            o_rd_addr <= issue_rd;
            o_rd_data <= issue_data;
        end else begin
            o_we      <= 1'b0;
        end
    end

    // Sticky error: a pipeline write arrived while the pipeline was told to stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_err <= 1'b0;
        end else if (drop) begin
            o_err <= 1'b1;
        end
    end

    // Busy lookup: a source is busy if a buffered entry or the in-flight write targets it.
    always_comb begin
        rs1_hit = 1'b0;
        rs2_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_vld[i] && (fifo_rd[i] == i_rs1_addr)) rs1_hit = 1'b1;
            if (fifo_vld[i] && (fifo_rd[i] == i_rs2_addr)) rs2_hit = 1'b1;
        end
        if (o_we && (o_rd_addr == i_rs1_addr)) rs1_hit = 1'b1;
        if (o_we && (o_rd_addr == i_rs2_addr)) rs2_hit = 1'b1;
        o_rs1_busy = (i_rs1_addr != '0) && rs1_hit;
        o_rs2_busy = (i_rs2_addr != '0) && rs2_hit;
    end

endmodule

// File: tb/tb_rv32im_wb_arbiter.sv
// tb_rv32im_wb_arbiter: directed stimulus with a write scoreboard.
// Expected register-file writes are queued as stimulus is issued.
// A monitor pops and compares one entry on every o_we pulse.

module tb_rv32im_wb_arbiter;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    logic        clk;
    logic        rst;
    logic        i_pipe_valid;
    logic [4:0]  i_pipe_rd;
    logic [31:0] i_pipe_data;
    logic        i_lo_valid;
    logic        o_lo_ready;
    logic [4:0]  i_lo_rd;
    logic [31:0] i_lo_data;
    logic        o_we;
    logic [4:0]  o_rd_addr;
    logic [31:0] o_rd_data;
    logic [4:0]  i_rs1_addr;
    logic [4:0]  i_rs2_addr;
    logic        o_rs1_busy;
    logic        o_rs2_busy;
    logic        o_stall;
    logic        o_err;

    int  checks = 0;
    int  errors = 0;
    wb_t exp_q[$];

    rv32im_wb_arbiter #(
        .WIDTH(32), .ADDR_WIDTH(5), .DEPTH(2), .MAX_WAIT(8)
    ) dut (
        .clk(clk), .rst(rst),
        .i_pipe_valid(i_pipe_valid), .i_pipe_rd(i_pipe_rd), .i_pipe_data(i_pipe_data),
        .i_lo_valid(i_lo_valid), .o_lo_ready(o_lo_ready),
        .i_lo_rd(i_lo_rd), .i_lo_data(i_lo_data),
        .o_we(o_we), .o_rd_addr(o_rd_addr), .o_rd_data(o_rd_data),
        .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
        .o_rs1_busy(o_rs1_busy), .o_rs2_busy(o_rs2_busy),
        .o_stall(o_stall), .o_err(o_err)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Absolute time limit so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Monitor: every register-file write must match the oldest expected write.
    initial begin
        wb_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && o_we) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL wb_write: got rd=%0d data=0x%08h expected no write",
                             o_rd_addr, o_rd_data);
                end else begin
                    e = exp_q.pop_front();
                    if (o_rd_addr !== e.rd || o_rd_data !== e.data) begin
                        errors++;
                        $display("[TB] FAIL wb_write: got rd=%0d data=0x%08h expected rd=%0d data=0x%08h",
                                 o_rd_addr, o_rd_data, e.rd, e.data);
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input logic pv, input logic [4:0] prd, input logic [31:0] pdata,
                                 input logic lv, input logic [4:0] lrd, input logic [31:0] ldata);
        i_pipe_valid = pv;
        i_pipe_rd    = prd;
        i_pipe_data  = pdata;
        i_lo_valid   = lv;
        i_lo_rd      = lrd;
        i_lo_data    = ldata;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic expectWrite(input logic [4:0] rd, input logic [31:0] data);
        exp_q.push_back('{rd: rd, data: data});
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    endtask

    initial begin
        rst        = 1'b1;
        i_rs1_addr = 5'd0;
        i_rs2_addr = 5'd0;
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_we",    o_we,       0);
        checkOutput("reset_addr",  o_rd_addr,  0);
        checkOutput("reset_data",  o_rd_data,  0);
        checkOutput("reset_ready", o_lo_ready, 1);
        checkOutput("reset_stall", o_stall,    0);
        checkOutput("reset_err",   o_err,      0);
        nextCycle();
        rst = 1'b0;

        // Pipe write, then a pipe write to x0 that must be suppressed.
        $display("[TB] pipe write");
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
        expectWrite(5'd5, 32'hDEADBEEF);
        @(negedge clk); nextCycle();
        idle();
        @(negedge clk);
        checkOutput("pipe_we",   o_we,      1);
        checkOutput("pipe_addr", o_rd_addr, 5);
        checkOutput("pipe_data", o_rd_data, 32'hDEADBEEF);
        nextCycle();
        @(negedge clk);
        checkOutput("pipe_we_off", o_we, 0);
        nextCycle();
        applyStimulus(1'b1, 5'd0, 32'h11111111, 1'b0, 5'd0, 32'h0);
        @(negedge clk); nextCycle();
        idle();
        @(negedge clk);
        checkOutput("x0_we",        o_we,      0);
        checkOutput("x0_addr_hold", o_rd_addr, 5);
        checkOutput("x0_data_hold", o_rd_data, 32'hDEADBEEF);
        nextCycle();

        // Long op drained into a pipeline bubble, with rs1 interlock.
        $display("[TB] drain into bubble");
        i_rs1_addr = 5'd7;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h12345678);
        expectWrite(5'd7, 32'h12345678);
        @(negedge clk);
        checkOutput("drain_ready_c0", o_lo_ready, 1);
        checkOutput("drain_busy_c0",  o_rs1_busy, 0);
        nextCycle(); idle();
        @(negedge clk);
        checkOutput("drain_busy_c1", o_rs1_busy, 1);
        checkOutput("drain_we_c1",   o_we,       0);
        nextCycle();
        @(negedge clk);
        checkOutput("drain_we_c2",   o_we,       1);
        checkOutput("drain_addr_c2", o_rd_addr,  7);
        checkOutput("drain_busy_c2", o_rs1_busy, 1);
        nextCycle();
        @(negedge clk);
        checkOutput("drain_busy_c3", o_rs1_busy, 0);
        checkOutput("drain_we_c3",   o_we,       0);
        i_rs1_addr = 5'd0;
        nextCycle();

        // Full FIFO back-pressure and ordering.
        $display("[TB] full and back-pressure");
        applyStimulus(1'b1, 5'd10, 32'hA0000010, 1'b1, 5'd1, 32'hC0000001);
        expectWrite(5'd10, 32'hA0000010);
        @(negedge clk); checkOutput("full_ready_c0", o_lo_ready, 1); nextCycle();
        applyStimulus(1'b1, 5'd11, 32'hA0000011, 1'b1, 5'd2, 32'hC0000002);
        expectWrite(5'd11, 32'hA0000011);
        @(negedge clk); checkOutput("full_ready_c1", o_lo_ready, 1); nextCycle();
        applyStimulus(1'b1, 5'd12, 32'hA0000012, 1'b1, 5'd3, 32'hC0000003);
        expectWrite(5'd12, 32'hA0000012);
        @(negedge clk); checkOutput("full_ready_c2", o_lo_ready, 0); nextCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'hC0000003);
        expectWrite(5'd1, 32'hC0000001);
        @(negedge clk); checkOutput("full_ready_c3", o_lo_ready, 0); nextCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'hC0000003);
        expectWrite(5'd2, 32'hC0000002);
        @(negedge clk);
        checkOutput("full_ready_c4", o_lo_ready, 1);
        checkOutput("full_addr_c4",  o_rd_addr,  1);
        nextCycle();
        idle();
        expectWrite(5'd3, 32'hC0000003);
        @(negedge clk); checkOutput("full_addr_c5", o_rd_addr, 2); nextCycle();
        @(negedge clk); checkOutput("full_addr_c6", o_rd_addr, 3); nextCycle();
        @(negedge clk); checkOutput("full_we_c7",   o_we,      0); nextCycle();

        // Starvation guard with the pipeline honouring o_stall.
        $display("[TB] starvation");
        for (int c = 0; c < 9; c++) begin
            applyStimulus(1'b1, 5'd20, 32'h2000 + c, (c == 0), 5'd9, 32'h99999999);
            expectWrite(5'd20, 32'h2000 + c);
            @(negedge clk);
            if (c == 0 || c == 8) checkOutput("starve_stall_low", o_stall, 0);
            nextCycle();
        end
        idle();
        expectWrite(5'd9, 32'h99999999);
        @(negedge clk); checkOutput("starve_stall_c9", o_stall, 1); nextCycle();
        applyStimulus(1'b1, 5'd20, 32'h200A, 1'b0, 5'd0, 32'h0);
        expectWrite(5'd20, 32'h200A);
        @(negedge clk);
        checkOutput("starve_stall_c10", o_stall,   0);
        checkOutput("starve_we_c10",    o_we,      1);
        checkOutput("starve_addr_c10",  o_rd_addr, 9);
        checkOutput("starve_data_c10",  o_rd_data, 32'h99999999);
        nextCycle();
        idle();
        @(negedge clk); checkOutput("starve_addr_c11", o_rd_addr, 20); nextCycle();

        // Protocol violation: pipe write while stalled is dropped and o_err sticks.
        $display("[TB] protocol violation");
        for (int c = 0; c < 9; c++) begin
            applyStimulus(1'b1, 5'd4, 32'h4000 + c, (c == 0), 5'd6, 32'h66666666);
            expectWrite(5'd4, 32'h4000 + c);
            @(negedge clk); nextCycle();
        end
        applyStimulus(1'b1, 5'd4, 32'h4009, 1'b0, 5'd0, 32'h0);
        expectWrite(5'd6, 32'h66666666);
        @(negedge clk);
        checkOutput("viol_stall_c9", o_stall, 1);
        checkOutput("viol_err_c9",   o_err,   0);
        nextCycle();
        idle();
        @(negedge clk);
        checkOutput("viol_err_c10",  o_err,     1);
        checkOutput("viol_addr_c10", o_rd_addr, 6);
        nextCycle();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk); checkOutput("viol_err_sticky", o_err, 1); nextCycle();
        end

        // Asynchronous reset mid-stream with two buffered entries.
        $display("[TB] reset mid-stream");
        applyStimulus(1'b1, 5'd0, 32'h0, 1'b1, 5'd1, 32'h000000F1);
        @(negedge clk); nextCycle();
        applyStimulus(1'b1, 5'd13, 32'h0000D00D, 1'b1, 5'd2, 32'h000000F2);
        expectWrite(5'd13, 32'h0000D00D);
        @(negedge clk); nextCycle();
        applyStimulus(1'b1, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        i_rs1_addr = 5'd1;
        i_rs2_addr = 5'd2;
        @(negedge clk);
        checkOutput("pre_rst_ready", o_lo_ready, 0);
        checkOutput("pre_rst_busy1", o_rs1_busy, 1);
        checkOutput("pre_rst_busy2", o_rs2_busy, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rst_we",    o_we,       0);
        checkOutput("rst_ready", o_lo_ready, 1);
        checkOutput("rst_stall", o_stall,    0);
        checkOutput("rst_busy1", o_rs1_busy, 0);
        checkOutput("rst_busy2", o_rs2_busy, 0);
        checkOutput("rst_err",   o_err,      0);
        nextCycle();
        idle();
        nextCycle();
        rst = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            checkOutput("post_rst_we",    o_we,    0);
            checkOutput("post_rst_stall", o_stall, 0);
            nextCycle();
        end

        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
